// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit positions and FSM states shared by alu_seq and alu_seq_step.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_MOV = 4'd6,
        OP_INC = 4'd7,
        OP_DEC = 4'd8,
        OP_SLA = 4'd9,
        OP_SLL = 4'd10,
        OP_ROL = 4'd11,
        OP_SRA = 4'd12,
        OP_SRL = 4'd13,
        OP_ROR = 4'd14,
        OP_ADC = 4'd15
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SLA) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu_seq_step.sv
// alu_seq_step: combinational ALU plus one-bit shift step, or a full barrel shifter
// when ALU_SEQ_BARREL_EN is defined.
module alu_seq_step
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef ALU_SEQ_BARREL_EN
    , parameter int SHAMT_W = $clog2(WIDTH)
`endif
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
`ifdef ALU_SEQ_BARREL_EN
    input  logic [SHAMT_W-1:0] i_shamt,
`endif
    output logic [WIDTH-1:0] o_res,
    output logic             o_c,
    output logic             o_v
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] w_addb, w_subb;
    logic [WIDTH:0]   w_sum, w_diff;

    assign w_addb = (i_op == OP_INC) ? WIDTH'(1) : i_b;
    assign w_subb = (i_op == OP_DEC) ? WIDTH'(1) : i_b;
    assign w_sum  = {1'b0, i_a} + {1'b0, w_addb} + {{WIDTH{1'b0}}, (i_op == OP_ADC) & i_c_in};
    assign w_diff = {1'b0, i_a} - {1'b0, w_subb};

`ifdef ALU_SEQ_BARREL_EN
    logic             w_nz, w_slav;
    logic [WIDTH-1:0] w_lt, w_rt;
    logic [2*WIDTH-1:0] w_rl, w_rr;

    assign w_nz = |i_shamt;
    assign w_lt = i_a << (i_shamt - 1'b1);
    assign w_rt = i_a >> (i_shamt - 1'b1);
    assign w_rl = {i_a, i_a} << i_shamt;
    assign w_rr = {i_a, i_a} >> i_shamt;

    // SLA overflow: any of the bits that pass through the MSB differs from the original MSB
    always_comb begin
        w_slav = 1'b0;
        for (int i = 1; i < WIDTH; i++)
            if (i <= int'(i_shamt) && i_a[M-i] != i_a[M]) w_slav = 1'b1;
    end
`endif

    always_comb begin
        o_res = '0;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (i_op)
            OP_ADD, OP_ADC, OP_INC: begin
                o_res = w_sum[M:0];
                o_c   = w_sum[WIDTH];
                o_v   = (i_a[M] == w_addb[M]) && (w_sum[M] != i_a[M]);
            end
            OP_SUB, OP_DEC: begin
                o_res = w_diff[M:0];
                o_c   = w_diff[WIDTH];
                o_v   = (i_a[M] != w_subb[M]) && (w_diff[M] != i_a[M]);
            end
            OP_AND: o_res = i_a & i_b;
            OP_OR:  o_res = i_a | i_b;
            OP_XOR: o_res = i_a ^ i_b;
            OP_NOT: o_res = ~i_a;
            OP_MOV: o_res = i_a;
`ifdef ALU_SEQ_BARREL_EN
            OP_SLA, OP_SLL: begin
                o_res = i_a << i_shamt;
                o_c   = w_nz & w_lt[M];
                o_v   = (i_op == OP_SLA) & w_slav;
            end
            OP_ROL: begin
                o_res = w_rl[2*WIDTH-1:WIDTH];
                o_c   = w_nz & w_rl[WIDTH];
            end
            OP_SRA: begin
                o_res = $signed(i_a) >>> i_shamt;
                o_c   = w_nz & w_rt[0];
            end
            OP_SRL: begin
                o_res = i_a >> i_shamt;
                o_c   = w_nz & w_rt[0];
            end
            OP_ROR: begin
                o_res = w_rr[M:0];
                o_c   = w_nz & w_rr[M];
            end
`else
            OP_SLA, OP_SLL: begin
                o_res = {i_a[M-1:0], 1'b0};
                o_c   = i_a[M];
                o_v   = (i_op == OP_SLA) && (i_a[M] != i_a[M-1]);
            end
            OP_ROL: begin
                o_res = {i_a[M-1:0], i_a[M]};
                o_c   = i_a[M];
            end
            OP_SRA: begin
                o_res = {i_a[M], i_a[M:1]};
                o_c   = i_a[0];
            end
            OP_SRL: begin
                o_res = {1'b0, i_a[M:1]};
                o_c   = i_a[0];
            end
            OP_ROR: begin
                o_res = {i_a[0], i_a[M:1]};
                o_c   = i_a[0];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative one-bit-per-cycle shifts; defining
// ALU_SEQ_BARREL_EN makes every op single-cycle via a barrel shifter.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags
);

    state_e           r_state;
    logic             r_in_ready, r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_sa, w_step_res, w_res;
    logic             w_step_c, w_step_v, w_c, w_v;
    logic [3:0]       w_flags;

`ifdef ALU_SEQ_BARREL_EN
    assign w_op  = op;
    assign w_sa  = a;
    assign w_res = w_step_res;
    assign w_c   = w_step_c;
    assign w_v   = w_step_v;
`else
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_vacc;
    logic               w_pass;

    // While iterating, the step unit works on the shift register instead of the inputs
    assign w_op   = (r_state == S_EXEC) ? r_op : op;
    assign w_sa   = (r_state == S_EXEC) ? r_work : a;
    assign w_pass = (r_state == S_IDLE) && is_shift(op);
    assign w_res  = w_pass ? a : w_step_res;
    assign w_c    = !w_pass && w_step_c;
    assign w_v    = !w_pass && (w_step_v || r_vacc);
`endif

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_Z] = ~|w_res;
        w_flags[FLAG_S] = w_res[WIDTH-1];
        w_flags[FLAG_V] = w_v;
    end

    alu_seq_step #(
        .WIDTH(WIDTH)
`ifdef ALU_SEQ_BARREL_EN
        , .SHAMT_W(SHAMT_W)
`endif
    ) u_step (
        .i_op(w_op),
        .i_a(w_sa),
        .i_b(b),
        .i_c_in(c_in),
`ifdef ALU_SEQ_BARREL_EN
        .i_shamt(shamt),
`endif
        .o_res(w_step_res),
        .o_c(w_step_c),
        .o_v(w_step_v)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
`ifndef ALU_SEQ_BARREL_EN
            r_op        <= '0;
            r_work      <= '0;
            r_cnt       <= '0;
            r_vacc      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
`ifndef ALU_SEQ_BARREL_EN
                    if (is_shift(op) && shamt != '0) begin
                        r_op       <= op;
                        r_work     <= a;
                        r_cnt      <= shamt;
                        r_vacc     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EXEC;
                    end else
`endif
                    begin
                        r_result    <= w_res;
                        r_flags     <= w_flags;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`ifndef ALU_SEQ_BARREL_EN
                S_EXEC: begin
                    r_work <= w_step_res;
                    r_cnt  <= r_cnt - 1'b1;
                    r_vacc <= r_vacc | w_step_v;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result    <= w_res;
                        r_flags     <= w_flags;
                        r_vacc      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus backpressure and reset-mid-shift sequences for alu_seq.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;
    localparam int SW = 4;

    logic          clk, rst_n, in_valid, in_ready, c_in, out_valid, out_ready;
    logic [3:0]    op, flags;
    logic [W-1:0]  a, b, result;
    logic [SW-1:0] shamt;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [SW-1:0] sh;
        logic          cin;
        logic [W-1:0]  res;
        logic [3:0]    fl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef ALU_SEQ_BARREL_EN
        return 1;
`else
        return (is_shift(v.op) && v.sh != 0) ? int'(v.sh) + 1 : 1;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        op = v.op; a = v.a; b = v.b; shamt = v.sh; c_in = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = OP_NOT; a = 16'hDEAD; b = 16'hBEEF; shamt = 4'd7; c_in = 1'b1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat(v));
        chk({tag, ".result"}, result, v.res);
        chk({tag, ".flags"}, flags, v.fl);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // flags field is {V,S,Z,C}
        vecs.push_back('{OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 16'h8000, 4'b1100});
        vecs.push_back('{OP_SUB, 16'h0003, 16'h0005, 4'd0, 1'b0, 16'hFFFE, 4'b0101});
        vecs.push_back('{OP_ADC, 16'hFFFF, 16'h0000, 4'd0, 1'b1, 16'h0000, 4'b0011});
        vecs.push_back('{OP_SRA, 16'h8001, 16'h0000, 4'd3, 1'b0, 16'hF000, 4'b0100});
        vecs.push_back('{OP_ROR, 16'h0001, 16'h0000, 4'd1, 1'b0, 16'h8000, 4'b0101});
        vecs.push_back('{OP_SLA, 16'h4000, 16'h0000, 4'd1, 1'b0, 16'h8000, 4'b1100});
        vecs.push_back('{OP_ROL, 16'hA5A5, 16'h0000, 4'd0, 1'b0, 16'hA5A5, 4'b0100});
        vecs.push_back('{OP_AND, 16'hF0F0, 16'h3C3C, 4'd0, 1'b0, 16'h3030, 4'b0000});
        vecs.push_back('{OP_OR,  16'h00F0, 16'h0F00, 4'd0, 1'b0, 16'h0FF0, 4'b0000});
        vecs.push_back('{OP_XOR, 16'hAAAA, 16'hAAAA, 4'd0, 1'b0, 16'h0000, 4'b0010});
        vecs.push_back('{OP_NOT, 16'h0000, 16'h0000, 4'd0, 1'b0, 16'hFFFF, 4'b0100});
        vecs.push_back('{OP_MOV, 16'h1234, 16'h5678, 4'd0, 1'b0, 16'h1234, 4'b0000});
        vecs.push_back('{OP_INC, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'b0011});
        vecs.push_back('{OP_DEC, 16'h8000, 16'h0000, 4'd0, 1'b0, 16'h7FFF, 4'b1000});
        vecs.push_back('{OP_SLL, 16'h1801, 16'h0000, 4'd4, 1'b0, 16'h8010, 4'b0101});
        vecs.push_back('{OP_SRL, 16'h8003, 16'h0000, 4'd2, 1'b0, 16'h2000, 4'b0001});
        vecs.push_back('{OP_ROL, 16'h8001, 16'h0000, 4'd1, 1'b0, 16'h0003, 4'b0001});
        vecs.push_back('{OP_SLA, 16'h2000, 16'h0000, 4'd2, 1'b0, 16'h8000, 4'b1100});
        vecs.push_back('{OP_SLA, 16'hC000, 16'h0000, 4'd1, 1'b0, 16'h8000, 4'b0101});
        vecs.push_back('{OP_ADD, 16'h8000, 16'h8000, 4'd0, 1'b0, 16'h0000, 4'b1011});
        vecs.push_back('{OP_SUB, 16'h0000, 16'h8000, 4'd0, 1'b0, 16'h8000, 4'b1101});
        vecs.push_back('{OP_ADC, 16'h7FFF, 16'h0000, 4'd0, 1'b1, 16'h8000, 4'b1100});
        vecs.push_back('{OP_ADD, 16'h0001, 16'h0001, 4'd0, 1'b1, 16'h0002, 4'b0000});
        vecs.push_back('{OP_SRA, 16'h4000, 16'h0000, 4'd15, 1'b0, 16'h0000, 4'b0011});
        vecs.push_back('{OP_ROR, 16'h1234, 16'h0000, 4'd15, 1'b0, 16'h2468, 4'b0000});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; shamt = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.result", result, 0);
        chk("reset.flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result held, further requests ignored while DONE
        @(negedge clk);
        op = OP_ADD; a = 16'h0001; b = 16'h0002; c_in = 1'b0; shamt = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.out_valid_first", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = k[0]; op = OP_NOT; a = 16'h00FF;
            @(posedge clk); #1;
            chk($sformatf("bp.result%0d", k), result, 16'h0003);
            chk($sformatf("bp.flags%0d", k), flags, 4'b0000);
            chk($sformatf("bp.out_valid%0d", k), out_valid, 1);
            chk($sformatf("bp.in_ready%0d", k), in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.release_out_valid", out_valid, 0);
        chk("bp.release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("bp.idle_out_valid", out_valid, 0);
        chk("bp.idle_result", result, 16'h0003);

        // Reset during the third EXEC cycle of a long shift
        @(negedge clk);
        op = OP_SLL; a = 16'hFFFF; shamt = 4'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst.busy_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{OP_MOV, 16'h1234, 16'h0000, 4'd0, 1'b0, 16'h1234, 4'b0000}, "rst.mov");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the nlp-16a ALU control decoder.
- Accepts one ALU operation per transaction: opcode, operands, shift amount, carry-in.
- Returns a registered result plus C/Z/S/V flags.
- Multi-bit shifts/rotates run iteratively, one bit per cycle, so the datapath keeps a single-bit shifter. Sits between the instruction decoder and the register-file write-back.

Parameters:
- WIDTH, 16, data/result width in bits (≥4).
- SHAMT_W, $clog2(WIDTH), shift-amount width; maximum shift is WIDTH-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  opcode from alu_seq_pkg.
- a  in  WIDTH  operand A; the shift/unary source.
- b  in  WIDTH  operand B.
- shamt  in  SHAMT_W  shift count; ignored for non-shift ops.
- c_in  in  1  carry flag input, used by ADC only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {V,S,Z,C}, registered.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: in_ready=1, out_valid=0, result=0, flags=0, state IDLE. Reset mid-operation discards work; IDLE on the next edge.
- FSM states are IDLE, EXEC, DONE.
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
    - Non-shift ops: result/flags registered on the accept edge, then DONE.
    - Shift ops with shamt=0: result=a, C=0, V=0, then DONE.
    - Shift ops with shamt≥1: work reg loaded with a, count=shamt, then EXEC.
  - EXEC: in_ready=0. Each edge applies a one-bit step and decrements count. The edge where count reaches 0 registers result/flags and moves to DONE.
  - DONE: out_valid=1, result/flags held stable. On out_ready, return to IDLE; out_valid=0 next cycle.
  - No accept in the same cycle as an output transfer. Peak throughput is one op per 2 cycles.
- Latency from accept edge to out_valid high:
  - 1 cycle for non-shift ops and shamt=0.
  - shamt+1 cycles for shifts.
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT (~a), 6 MOV (a), 7 INC (a+1), 8 DEC (a-1).
  - 9 SLA, 10 SLL, 11 ROL, 12 SRA, 13 SRL, 14 ROR.
  - 15 ADC (a+b+c_in).
- Arithmetic is WIDTH-bit modulo.
- C flag:
  - ADD/ADC/INC: carry-out.
  - SUB/DEC: borrow, 1 when unsigned a < subtrahend.
  - Logic/MOV/NOT: C=0.
  - Shifts/rotates: C = last bit shifted or rotated out.
  - Rotates do not go through carry.
- V flag:
  - Arithmetic ops: two's-complement overflow.
  - SLA: V=1 if the MSB changed on any step.
  - All other ops: V=0.
- S = result[WIDTH-1]; Z = (result==0) for all ops.
- SRA replicates the MSB. SLA and SLL produce the same result; only V differs.
- Inputs are sampled only on the accept edge. Changes while busy have no effect.

Optional Feature:
- ALU_SEQ_BARREL_EN defined: shifts and rotates complete in one cycle via a barrel shifter. Latency is 1 for every op and EXEC is never entered. Result and flags are bit-identical to the iterative mode, including SLA's V as "any MSB change".
- Not defined: iterative shifting as described in Behaviour.

Decomposition:
- alu_seq_pkg holds:
  - the op enum (4-bit) and its encodings;
  - flag bit index constants FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_V=3;
  - the state enum.
- Sub-module alu_seq_step is purely combinational. It holds the single-cycle arithmetic/logic unit plus the one-bit shift step (or the barrel shifter under the macro), and outputs next value and C/V.
- alu_seq holds the FSM, counter, handshake and registers.

Test Plan:
- ADD a=0x7FFF b=0x0001 → result 0x8000, flags V1 S1 Z0 C0; out_valid exactly 1 cycle after accept.
- SUB a=0x0003 b=0x0005 → 0xFFFE, C1 S1 V0 Z0. ADC a=0xFFFF b=0x0000 c_in=1 → 0x0000, C1 Z1 V0.
- Shifts:
  - SRA a=0x8001 shamt=3 → 0xF000, C0 S1; out_valid 4 cycles after accept (1 with ALU_SEQ_BARREL_EN).
  - ROR a=0x0001 shamt=1 → 0x8000, C1.
  - SLA a=0x4000 shamt=1 → 0x8000, V1 C0.
- Backpressure: hold out_ready=0 for 5 cycles after DONE → result/flags stable, out_valid=1, in_ready=0, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle.
- Reset mid-shift: SLL a=0xFFFF shamt=15, drive rst_n=0 during the third EXEC cycle → next edge in_ready=1, out_valid=0, result=0, flags=0. A following MOV a=0x1234 returns 0x1234.
- shamt=0 on ROL a=0xA5A5 → 0xA5A5, C0 V0, latency 1.
